// File: rtl/r_ptr_empty_ctrl.sv
// Read-side pointer, empty flag and fill-level controller for an async FIFO.
// Optional level sanity check enabled with `define R_LEVEL_CHECK_EN (adds r_level_err).
module r_ptr_empty_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter bit AE_RESET   = 1'b1
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic                  r_inc,
    input  logic [ADDR_WIDTH:0]   r_q2_w_ptr,
    input  logic [ADDR_WIDTH:0]   r_ae_thresh,
    input  logic                  r_err_clr,
    output logic                  r_rd_en,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   r_ptr,
    output logic                  r_empty,
    output logic                  r_almost_empty,
    output logic [ADDR_WIDTH:0]   r_level,
    output logic                  r_underflow,
    output logic                  r_underflow_sticky
`ifdef R_LEVEL_CHECK_EN
    ,
    output logic                  r_level_err
`endif
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [PW-1:0] bin_q;
    logic [PW-1:0] bin_d;
    logic [PW-1:0] gray_d;
    logic [PW-1:0] w_bin;
    logic [PW-1:0] level_d;
    logic          empty_d;
    logic          ae_d;
    logic          sticky_d;

    // Gray-to-binary: each bit is the XOR of itself and all higher Gray bits.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign w_bin[gi] = ^r_q2_w_ptr[PW-1:gi];
        end
    endgenerate

    assign r_rd_en  = r_inc & ~r_empty;
    assign bin_d    = bin_q + {{ADDR_WIDTH{1'b0}}, r_rd_en};
    assign gray_d   = (bin_d >> 1) ^ bin_d;
    assign level_d  = w_bin - bin_d;
    assign ae_d     = (level_d <= r_ae_thresh);
    assign sticky_d = (r_inc & r_empty) | (r_underflow_sticky & ~r_err_clr);
    assign r_addr   = bin_q[ADDR_WIDTH-1:0];

`ifdef R_LEVEL_CHECK_EN
    logic level_err_d;
    // A level above DEPTH means the synchronised write pointer is corrupt; hold the FIFO empty.
    assign level_err_d = r_level_err | (level_d > DEPTH);
    assign empty_d     = (gray_d == r_q2_w_ptr) | level_err_d;

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            r_level_err <= 1'b0;
        end else begin
            r_level_err <= level_err_d;
        end
    end
`else
    assign empty_d = (gray_d == r_q2_w_ptr);
`endif

    always_ff @(posedge r_clk) begin
        if (r_rst) begin
            bin_q              <= '0;
            r_ptr              <= '0;
            r_empty            <= 1'b1;
            r_level            <= '0;
            r_almost_empty     <= AE_RESET;
            r_underflow        <= 1'b0;
            r_underflow_sticky <= 1'b0;
        end else begin
            bin_q              <= bin_d;
            r_ptr              <= gray_d;
            r_empty            <= empty_d;
            r_level            <= level_d;
            r_almost_empty     <= ae_d;
            r_underflow        <= r_inc & r_empty;
            r_underflow_sticky <= sticky_d;
        end
    end

endmodule

// File: tb/tb_r_ptr_empty_ctrl.sv
// Scoreboard bench for r_ptr_empty_ctrl: directed vectors queue expected results, a monitor checks them.
module tb_r_ptr_empty_ctrl;

    logic       r_clk = 1'b0;
    logic       r_rst = 1'b1;
    logic       r_inc = 1'b0;
    logic [4:0] r_q2_w_ptr = '0;
    logic [4:0] r_ae_thresh = 5'd1;
    logic       r_err_clr = 1'b0;
    logic       r_rd_en;
    logic [3:0] r_addr;
    logic [4:0] r_ptr;
    logic       r_empty;
    logic       r_almost_empty;
    logic [4:0] r_level;
    logic       r_underflow;
    logic       r_underflow_sticky;
`ifdef R_LEVEL_CHECK_EN
    logic       r_level_err;
`endif

    r_ptr_empty_ctrl #(.ADDR_WIDTH(4), .AE_RESET(1'b1)) dut (
        .r_clk              (r_clk),
        .r_rst              (r_rst),
        .r_inc              (r_inc),
        .r_q2_w_ptr         (r_q2_w_ptr),
        .r_ae_thresh        (r_ae_thresh),
        .r_err_clr          (r_err_clr),
        .r_rd_en            (r_rd_en),
        .r_addr             (r_addr),
        .r_ptr              (r_ptr),
        .r_empty            (r_empty),
        .r_almost_empty     (r_almost_empty),
        .r_level            (r_level),
        .r_underflow        (r_underflow),
        .r_underflow_sticky (r_underflow_sticky)
`ifdef R_LEVEL_CHECK_EN
        ,
        .r_level_err        (r_level_err)
`endif
    );

    always #5 r_clk = ~r_clk;

    typedef struct {
        int       id;
        logic     rd_en;
        logic [4:0] bin;
        logic     empty;
        logic     ae;
        logic [4:0] level;
        logic     uf;
        logic     ufs;
        logic     lerr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   n_issued = 0;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input int id, input int act, input int req);
        if (act != req) begin
            n_bad++;
            $display("FAIL vec %0d %s: got %0d expected %0d", id, name, act, req);
        end
    endtask

    // Inputs applied for one cycle; expectations are rd_en during the cycle and registered state after the edge.
    task automatic vec(input logic rst, input logic inc, input logic [4:0] wbin, input logic [4:0] thr,
                       input logic clr, input logic e_rd, input logic [4:0] e_bin, input logic e_empty,
                       input logic e_ae, input logic [4:0] e_lvl, input logic e_uf, input logic e_ufs,
                       input logic e_lerr);
        exp_t e;
        @(posedge r_clk);
        #2;
        r_rst       = rst;
        r_inc       = inc;
        r_q2_w_ptr  = g(wbin);
        r_ae_thresh = thr;
        r_err_clr   = clr;
        e.id = n_issued; e.rd_en = e_rd; e.bin = e_bin; e.empty = e_empty; e.ae = e_ae;
        e.level = e_lvl; e.uf = e_uf; e.ufs = e_ufs; e.lerr = e_lerr;
        exp_q.push_back(e);
        n_issued++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge r_clk);
            if (exp_q.size() > 0) begin
                chk("rd_en", exp_q[0].id, int'(r_rd_en), int'(exp_q[0].rd_en));
                @(posedge r_clk);
                #1;
                e = exp_q.pop_front();
                n_vec++;
                chk("addr", e.id, int'(r_addr), int'(e.bin[3:0]));
                chk("ptr", e.id, int'(r_ptr), int'(g(e.bin)));
                chk("empty", e.id, int'(r_empty), int'(e.empty));
                chk("almost_empty", e.id, int'(r_almost_empty), int'(e.ae));
                chk("level", e.id, int'(r_level), int'(e.level));
                chk("underflow", e.id, int'(r_underflow), int'(e.uf));
                chk("underflow_sticky", e.id, int'(r_underflow_sticky), int'(e.ufs));
`ifdef R_LEVEL_CHECK_EN
                chk("level_err", e.id, int'(r_level_err), int'(e.lerr));
`endif
            end
        end
    end

    initial begin : stimulus
        int budget;
        // One unchecked reset edge so the registered empty flag is defined.
        @(posedge r_clk);
        //    rst inc wbin thr  clr | rd  bin  emp ae lvl  uf ufs lerr
        vec(1, 1, 5'd0, 5'd1, 0,   0, 5'd0, 1, 1, 5'd0, 0, 0, 0);
        vec(1, 1, 5'd0, 5'd1, 0,   0, 5'd0, 1, 1, 5'd0, 0, 0, 0);
        vec(0, 0, 5'd3, 5'd1, 0,   0, 5'd0, 0, 0, 5'd3, 0, 0, 0);
        vec(0, 1, 5'd3, 5'd1, 0,   1, 5'd1, 0, 0, 5'd2, 0, 0, 0);
        vec(0, 1, 5'd3, 5'd1, 0,   1, 5'd2, 0, 1, 5'd1, 0, 0, 0);
        vec(0, 1, 5'd3, 5'd1, 0,   1, 5'd3, 1, 1, 5'd0, 0, 0, 0);
        // Underflow pulse, sticky set-wins, then clear
        vec(0, 1, 5'd3, 5'd1, 0,   0, 5'd3, 1, 1, 5'd0, 1, 1, 0);
        vec(0, 1, 5'd3, 5'd1, 1,   0, 5'd3, 1, 1, 5'd0, 1, 1, 0);
        vec(0, 0, 5'd3, 5'd1, 1,   0, 5'd3, 1, 1, 5'd0, 0, 0, 0);
        vec(0, 0, 5'd3, 5'd1, 0,   0, 5'd3, 1, 1, 5'd0, 0, 0, 0);
        // Write arrives, then last word read while the writer advances again
        vec(0, 0, 5'd4, 5'd1, 0,   0, 5'd3, 0, 1, 5'd1, 0, 0, 0);
        vec(0, 1, 5'd5, 5'd1, 0,   1, 5'd4, 0, 1, 5'd1, 0, 0, 0);
        // Threshold 0 tracks empty; threshold DEPTH is always asserted
        vec(0, 0, 5'd5, 5'd0, 0,   0, 5'd4, 0, 0, 5'd1, 0, 0, 0);
        vec(0, 1, 5'd5, 5'd0, 0,   1, 5'd5, 1, 1, 5'd0, 0, 0, 0);
        vec(0, 0, 5'd21, 5'd16, 0, 0, 5'd5, 0, 1, 5'd16, 0, 0, 0);
        // Full FIFO, reading and writing every cycle: write pointer wraps 31->0, level stays 16
        for (int i = 0; i < 24; i++) begin
            vec(0, 1, 5'((22 + i) % 32), 5'd16, 0, 1, 5'((6 + i) % 32), 0, 1, 5'd16, 0, 0, 0);
        end
        // Drain across the read-pointer wrap 30->31->0
        vec(0, 1, 5'd13, 5'd16, 0, 1, 5'd30, 0, 1, 5'd15, 0, 0, 0);
        vec(0, 1, 5'd13, 5'd16, 0, 1, 5'd31, 0, 1, 5'd14, 0, 0, 0);
        vec(0, 1, 5'd13, 5'd16, 0, 1, 5'd0,  0, 1, 5'd13, 0, 0, 0);
        vec(0, 0, 5'd13, 5'd1, 0,  0, 5'd0,  0, 0, 5'd13, 0, 0, 0);
        vec(0, 0, 5'd5,  5'd1, 0,  0, 5'd0,  0, 0, 5'd5,  0, 0, 0);
        // Mid-operation reset with level 5 and a live read request
        vec(1, 1, 5'd5, 5'd1, 0,   1, 5'd0, 1, 1, 5'd0, 0, 0, 0);
        vec(0, 0, 5'd5, 5'd1, 0,   0, 5'd0, 0, 0, 5'd5, 0, 0, 0);
`ifdef R_LEVEL_CHECK_EN
        // Corrupt write pointer giving level 20
        vec(0, 0, 5'd20, 5'd1, 0,  0, 5'd0, 1, 0, 5'd20, 0, 0, 1);
        vec(0, 1, 5'd3, 5'd1, 0,   0, 5'd0, 1, 0, 5'd3, 1, 1, 1);
`endif
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge r_clk);
            budget--;
        end
        #3;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d vectors unchecked, expected 0", exp_q.size());
        end
        if (n_vec != n_issued) begin
            n_bad++;
            $display("FAIL count: checked %0d vectors, expected %0d", n_vec, n_issued);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/r_ptr_empty_ctrl.md
Name: r_ptr_empty_ctrl

Overview:
Read-domain pointer, empty and occupancy controller for the async FIFO. It is the parametrised successor of the basic read-pointer/empty-flag block.
- Keeps the read binary/Gray pointers and a registered empty flag.
- Adds a registered fill level, a programmable almost-empty flag, a qualified read enable and underflow detection (pulse plus sticky).
- Sits between the read port, the FIFO RAM read address and the write-to-read pointer synchroniser.

Parameters:
ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
AE_RESET, 1, reset value of r_almost_empty (0 or 1).

Ports:
r_clk  in  1  read-domain clock; all logic on rising edge
r_rst  in  1  synchronous reset, active-high
r_inc  in  1  read request from consumer
r_q2_w_ptr  in  ADDR_WIDTH+1  write Gray pointer, already 2-flop synchronised
r_ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold in words; quasi-static
r_err_clr  in  1  clears r_underflow_sticky
r_rd_en  out  1  qualified read = r_inc & ~r_empty (combinational)
r_addr  out  ADDR_WIDTH  RAM read address = r_bin[ADDR_WIDTH-1:0]
r_ptr  out  ADDR_WIDTH+1  registered read Gray pointer, to write-side synchroniser
r_empty  out  1  registered empty flag
r_almost_empty  out  1  registered, level <= threshold
r_level  out  ADDR_WIDTH+1  registered words available, 0..DEPTH
r_underflow  out  1  one-cycle pulse on rejected read
r_underflow_sticky  out  1  latched underflow

Behaviour:
- Interface: one clock r_clk; reset r_rst is synchronous and active-high. Sampled only on the r_clk rising edge; no asynchronous path.
- Reset values while r_rst=1 at an edge:
  - r_bin=0, r_ptr=0, r_empty=1, r_level=0.
  - r_almost_empty=AE_RESET.
  - r_underflow=0, r_underflow_sticky=0.
  - Reset dominates all other inputs. Reset mid-operation discards pointer state, and the next cycle behaves as post-reset.
- Next-state arithmetic, all modulo 2**(ADDR_WIDTH+1):
  - r_binnext = r_bin + r_rd_en.
  - r_graynext = (r_binnext>>1) ^ r_binnext.
  - w_bin = Gray-to-binary of r_q2_w_ptr (XOR-prefix from MSB).
  - level_next = w_bin - r_binnext, unsigned ADDR_WIDTH+1 bits.
- Registered updates each edge:
  - r_bin<=r_binnext; r_ptr<=r_graynext.
  - r_empty<=(r_graynext==r_q2_w_ptr).
  - r_level<=level_next.
  - r_almost_empty<=(level_next<=r_ae_thresh).
- Latency:
  - A write pointer change at the r_q2_w_ptr input shows on r_empty/r_level/r_almost_empty one r_clk later.
  - A read updates r_addr/r_ptr/flags on the next edge.
- r_rd_en is combinational and used as the RAM read strobe. A read with r_empty=1 never moves the pointer.
- Underflow:
  - r_underflow<=r_inc & r_empty.
  - Sticky set when r_inc & r_empty; cleared by r_err_clr. Simultaneous set and clear: set wins.
- Wrap-around: the pointer wraps from 2**(ADDR_WIDTH+1)-1 to 0. Level stays correct across the wrap by modular subtraction.
- Simultaneous read and write-pointer advance: level_next reflects both.
- Last word read in the same cycle the write pointer advances by one: r_empty stays 0.
- r_level never exceeds DEPTH under legal operation. Values >DEPTH indicate synchroniser corruption (see option).
- r_ae_thresh=0: almost_empty equals empty. Threshold >=DEPTH: almost_empty is always 1.

Optional Feature:
- Macro: R_LEVEL_CHECK_EN.
- Defined:
  - Adds an extra output r_level_err (1 bit, reset 0), registered level_next>DEPTH.
  - When set, r_empty is forced to 1 on the same edge, so the consumer is protected.
  - Sticky until r_rst.
- Undefined: port absent, no check logic, r_empty purely from the Gray comparison.

Test Plan:
- Reset (ADDR_WIDTH=4, AE_RESET=1), hold r_rst=1 for 3 edges with r_inc=1 -> r_empty=1, r_ptr=0, r_level=0, r_almost_empty=1, r_underflow=0, r_rd_en=0.
- Release reset, r_q2_w_ptr=5'b00010 (bin 3), r_ae_thresh=1 -> after 1 edge: r_empty=0, r_level=3, r_almost_empty=0.
- Read 3 words back-to-back with r_inc=1 -> r_addr sequence 0,1,2; r_level 2,1,0; r_almost_empty asserts at level 1; r_empty=1 after third edge; r_ptr=5'b00010.
- Fourth r_inc while empty -> r_underflow pulses 1 cycle, sticky=1, r_addr stays 3. Then assert r_err_clr together with r_inc -> sticky stays 1. Then r_err_clr alone -> sticky 0.
- Wrap: drive write pointer through bin 31->0->2 while reading continuously -> r_bin wraps 31->0, r_level correct every cycle, no false empty.
- Synchronous reset asserted with r_level=5 -> next edge all outputs at reset values. With R_LEVEL_CHECK_EN, inject r_q2_w_ptr giving level 20 -> r_level_err=1, r_empty=1.
